// File: rtl/tx_block_sequencer.sv
// tx_block_sequencer
// Turns the MAC-side 8-byte frame stream into START / DATA / END / IDLE block
// requests for the 64B/66B encoder. It advances one block per gearbox enable,
// enforces an IDLE gap after every frame, and aborts a frame with END0 when the
// source underruns or presents an illegal byte mask.
//
// Ports
//   clk, reset            core clock, asynchronous active-high reset
//   en                    gearbox block-enable (one block consumed per en=1)
//   s_data/s_keep/s_last/s_valid/s_ready
//                         MAC beat stream; a beat is taken on s_valid && s_ready
//   enc_en                encoder enable (follows en)
//   enc_data              encoder data_in (combinational)
//   enc_valid_bytes       encoder valid_bytes (combinational)
//   err_underrun          registered one-cycle pulse, the cycle after a mid-frame s_valid drop
//   err_keep              registered one-cycle pulse, the cycle after an illegal s_keep
//   frames_sent           count of cleanly ended frames, wraps
module tx_block_sequencer #(
  parameter int unsigned IPG_BLOCKS = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [63:0]      s_data,
  input  logic [7:0]       s_keep,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             enc_en,
  output logic [63:0]      enc_data,
  output logic [7:0]       enc_valid_bytes,
  output logic             err_underrun,
  output logic             err_keep,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned IPG_W  = 4;

  localparam logic [DATA_W-1:0] START_DATA = 64'hD555_5555_5555_5500;
  localparam logic [KEEP_W-1:0] START_VB   = 8'hFE;
  localparam logic [KEEP_W-1:0] KEEP_FULL  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_TERM  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_IPG   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IPG_W-1:0]   r_ipg_cnt;
  logic [CNT_W-1:0]   r_frames_sent;
  logic               r_err_underrun;
  logic               r_err_keep;

  logic               w_keep_legal;
  logic [DATA_W-1:0]  w_masked_data;
  logic               w_frame_done;
  logic               w_underrun;
  logic               w_bad_keep;

  // Full beat, or a contiguous low mask (including 0x00) on the last beat.
  assign w_keep_legal = (s_keep == KEEP_FULL) ||
                        (s_last && ((s_keep & (s_keep + KEEP_W'(1))) == KEEP_W'(0)));

  // Zero every byte lane whose keep bit is clear.
  always_comb begin
    w_masked_data = '0;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      w_masked_data[i*8 +: 8] = s_keep[i] ? s_data[i*8 +: 8] : 8'h00;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IPG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and event decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_underrun   = 1'b0;
    w_bad_keep   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en && s_valid) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (en) begin
          if (!s_valid) begin
            w_underrun  = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else if (!w_keep_legal) begin
            w_bad_keep  = 1'b1;
            w_state_nxt = s_last ? ST_IPG : ST_DRAIN;
          end else if (!s_last) begin
            w_state_nxt = ST_DATA;
          end else if (s_keep == KEEP_FULL) begin
            w_state_nxt = ST_TERM;
          end else begin
            w_frame_done = 1'b1;
            w_state_nxt  = ST_IPG;
          end
        end
      end
      ST_TERM: begin
        if (en) begin
          w_frame_done = 1'b1;
          w_state_nxt  = ST_IPG;
        end
      end
      ST_DRAIN: begin
        // s_ready is held high here even without en, so a last beat taken
        // while en=0 must still close the drain or the next frame is lost.
        if (s_valid && s_last) begin
          w_state_nxt = ST_IPG;
        end
      end
      ST_IPG: begin
        if (en && (r_ipg_cnt <= IPG_W'(1))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IPG;
      end
    endcase
  end

  // Block/handshake outputs; anything not overridden is an IDLE/END0 block.
  always_comb begin
    enc_data        = '0;
    enc_valid_bytes = '0;
    s_ready         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_valid) begin
          enc_data        = START_DATA;
          enc_valid_bytes = START_VB;
        end
      end
      ST_DATA: begin
        s_ready = en;
        if (s_valid && w_keep_legal) begin
          enc_data        = w_masked_data;
          enc_valid_bytes = s_keep;
        end
      end
      ST_DRAIN: begin
        s_ready = 1'b1;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  // Gap counter reloads whenever outside IPG, so every IPG entry starts full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ipg_cnt <= IPG_W'(IPG_BLOCKS);
    end else if (r_state != ST_IPG) begin
      r_ipg_cnt <= IPG_W'(IPG_BLOCKS);
    end else if (en) begin
      r_ipg_cnt <= r_ipg_cnt - IPG_W'(1);
    end
  end

  // Frame counter and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frames_sent  <= '0;
      r_err_underrun <= 1'b0;
      r_err_keep     <= 1'b0;
    end else begin
      if (w_frame_done) begin
        r_frames_sent <= r_frames_sent + CNT_W'(1);
      end
      r_err_underrun <= w_underrun;
      r_err_keep     <= w_bad_keep;
    end
  end

  assign enc_en       = en;
  assign frames_sent  = r_frames_sent;
  assign err_underrun = r_err_underrun;
  assign err_keep     = r_err_keep;

endmodule

// File: tb/tb_tx_block_sequencer.sv
// Directed bench for tx_block_sequencer with IPG_BLOCKS=3.
module tb_tx_block_sequencer;

  localparam int unsigned IPG   = 3;
  localparam int unsigned CNT_W = 32;

  localparam logic [63:0] START = 64'hD555_5555_5555_5500;
  localparam logic [63:0] A0  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] A1  = 64'h5555_6666_7777_8888;
  localparam logic [63:0] A2  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] A2M = 64'h0000_0000_00AB_CDEF;
  localparam logic [63:0] B0  = 64'h0706_0504_0302_0100;
  localparam logic [63:0] B1  = 64'h0F0E_0D0C_0B0A_0908;
  localparam logic [63:0] B2  = 64'h1716_1514_1312_1110;
  localparam logic [63:0] B3  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] B3M = 64'h0000_BA98_7654_3210;
  localparam logic [63:0] C0  = 64'hCAFE_F00D_DEAD_BEEF;
  localparam logic [63:0] C1  = 64'hA5A5_5A5A_0F0F_F0F0;

  logic             clk;
  logic             reset;
  logic             en;
  logic [63:0]      s_data;
  logic [7:0]       s_keep;
  logic             s_last;
  logic             s_valid;
  logic             s_ready;
  logic             enc_en;
  logic [63:0]      enc_data;
  logic [7:0]       enc_valid_bytes;
  logic             err_underrun;
  logic             err_keep;
  logic [CNT_W-1:0] frames_sent;

  int n_assert;
  int n_fail;

  tx_block_sequencer #(
    .IPG_BLOCKS(IPG),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .s_data         (s_data),
    .s_keep         (s_keep),
    .s_last         (s_last),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .enc_en         (enc_en),
    .enc_data       (enc_data),
    .enc_valid_bytes(enc_valid_bytes),
    .err_underrun   (err_underrun),
    .err_keep       (err_keep),
    .frames_sent    (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one block cycle (called at posedge+1), check combinational outputs
  // mid-cycle, then advance to the next posedge+1.
  task automatic blk(input string tag, input logic e, input logic v,
                     input logic [63:0] d, input logic [7:0] k, input logic l,
                     input logic [7:0] x_vb, input logic [63:0] x_d, input logic x_rdy);
    en      = e;
    s_valid = v;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    #2;
    chk({tag, "_vb"},  64'(enc_valid_bytes), 64'(x_vb));
    chk({tag, "_dat"}, enc_data, x_d);
    chk({tag, "_rdy"}, 64'(s_ready), 64'(x_rdy));
    chk({tag, "_en"},  64'(enc_en), 64'(e));
    @(posedge clk);
    #1;
  endtask

  // n en-cycles that must all show an IDLE block with s_ready low.
  task automatic idle_n(input string tag, input int n, input logic v, input logic [63:0] d);
    for (int i = 0; i < n; i++) begin
      blk(tag, 1'b1, v, d, 8'hFF, 1'b0, 8'h00, 64'h0, 1'b0);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    en       = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_keep   = '0;
    s_last   = 1'b0;
    #3;
    chk("rst_vb",  64'(enc_valid_bytes), 64'h0);
    chk("rst_dat", enc_data, 64'h0);
    chk("rst_rdy", 64'(s_ready), 64'h0);
    chk("rst_cnt", 64'(frames_sent), 64'h0);
    chk("rst_eu",  64'(err_underrun), 64'h0);
    chk("rst_ek",  64'(err_keep), 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle line: IPG then plain IDLE, never ready.
    idle_n("idle", 20, 1'b0, 64'h0);
    chk("idle_cnt", 64'(frames_sent), 64'h0);

    // 3-beat frame ending with keep 0x07.
    blk("f1_start", 1, 1, A0, 8'hFF, 0, 8'hFE, START, 0);
    blk("f1_b0",    1, 1, A0, 8'hFF, 0, 8'hFF, A0, 1);
    blk("f1_b1",    1, 1, A1, 8'hFF, 0, 8'hFF, A1, 1);
    blk("f1_b2",    1, 1, A2, 8'h07, 1, 8'h07, A2M, 1);
    chk("f1_cnt", 64'(frames_sent), 64'd1);
    chk("f1_eu",  64'(err_underrun), 64'h0);
    chk("f1_ek",  64'(err_keep), 64'h0);

    // Back-to-back 2-beat frame with full last beat: START waits for IPG.
    idle_n("f2_ipg", IPG, 1'b1, C0);
    blk("f2_start", 1, 1, C0, 8'hFF, 0, 8'hFE, START, 0);
    blk("f2_b0",    1, 1, C0, 8'hFF, 0, 8'hFF, C0, 1);
    blk("f2_b1",    1, 1, C1, 8'hFF, 1, 8'hFF, C1, 1);
    blk("f2_term",  1, 1, B0, 8'hFF, 0, 8'h00, 64'h0, 0);
    chk("f2_cnt", 64'(frames_sent), 64'd2);

    // 4-beat frame with en gaps; each beat taken once, on en=1 only.
    idle_n("f3_ipg", IPG, 1'b1, B0);
    blk("f3_start",   1, 1, B0, 8'hFF, 0, 8'hFE, START, 0);
    blk("f3_b0",      1, 1, B0, 8'hFF, 0, 8'hFF, B0, 1);
    blk("f3_b1_hold", 0, 1, B1, 8'hFF, 0, 8'hFF, B1, 0);
    blk("f3_b1",      1, 1, B1, 8'hFF, 0, 8'hFF, B1, 1);
    blk("f3_b2",      1, 1, B2, 8'hFF, 0, 8'hFF, B2, 1);
    blk("f3_b3_hold", 0, 1, B3, 8'h3F, 1, 8'h3F, B3M, 0);
    blk("f3_b3",      1, 1, B3, 8'h3F, 1, 8'h3F, B3M, 1);
    chk("f3_cnt", 64'(frames_sent), 64'd3);

    // IPG only counts en cycles; START held while en=0.
    blk("f4_ipg0",       1, 1, A0, 8'hFF, 0, 8'h00, 64'h0, 0);
    blk("f4_ipg_hold",   0, 1, A0, 8'hFF, 0, 8'h00, 64'h0, 0);
    blk("f4_ipg1",       1, 1, A0, 8'hFF, 0, 8'h00, 64'h0, 0);
    blk("f4_ipg2",       1, 1, A0, 8'hFF, 0, 8'h00, 64'h0, 0);
    blk("f4_start_hold", 0, 1, A0, 8'hFF, 0, 8'hFE, START, 0);
    blk("f4_start",      1, 1, A0, 8'hFF, 0, 8'hFE, START, 0);

    // Underrun after beat 2 of a 5-beat frame, remaining beats drained.
    blk("f4_b0",  1, 1, A0, 8'hFF, 0, 8'hFF, A0, 1);
    blk("f4_b1",  1, 1, A1, 8'hFF, 0, 8'hFF, A1, 1);
    blk("f4_gap", 1, 0, A2, 8'hFF, 0, 8'h00, 64'h0, 1);
    chk("f4_eu_pulse", 64'(err_underrun), 64'h1);
    chk("f4_ek",       64'(err_keep), 64'h0);
    blk("f4_d2",  1, 1, A2, 8'hFF, 0, 8'h00, 64'h0, 1);
    chk("f4_eu_clear", 64'(err_underrun), 64'h0);
    blk("f4_d3",  1, 1, C0, 8'hFF, 0, 8'h00, 64'h0, 1);
    blk("f4_d4",  1, 1, C1, 8'hFF, 1, 8'h00, 64'h0, 1);
    chk("f4_cnt", 64'(frames_sent), 64'd3);

    // Non-contiguous mask on the last beat.
    idle_n("f5_ipg", IPG, 1'b1, B0);
    blk("f5_start", 1, 1, B0, 8'hFF, 0, 8'hFE, START, 0);
    blk("f5_b0",    1, 1, B0, 8'hFF, 0, 8'hFF, B0, 1);
    blk("f5_b1",    1, 1, B1, 8'h0B, 1, 8'h00, 64'h0, 1);
    chk("f5_ek_pulse", 64'(err_keep), 64'h1);
    chk("f5_eu",       64'(err_underrun), 64'h0);
    chk("f5_cnt",      64'(frames_sent), 64'd3);

    // Partial mask on a non-last beat: abort and drain.
    idle_n("f6_ipg", IPG, 1'b1, C0);
    chk("f6_ek_clear", 64'(err_keep), 64'h0);
    blk("f6_start", 1, 1, C0, 8'hFF, 0, 8'hFE, START, 0);
    blk("f6_b0",    1, 1, C0, 8'h07, 0, 8'h00, 64'h0, 1);
    chk("f6_ek_pulse", 64'(err_keep), 64'h1);
    blk("f6_d1",    1, 1, C1, 8'hFF, 1, 8'h00, 64'h0, 1);
    chk("f6_cnt", 64'(frames_sent), 64'd3);

    // Reset asserted mid-frame: outputs go IDLE at once.
    idle_n("f7_ipg", IPG, 1'b1, A0);
    blk("f7_start", 1, 1, A0, 8'hFF, 0, 8'hFE, START, 0);
    blk("f7_b0",    1, 1, A0, 8'hFF, 0, 8'hFF, A0, 1);
    en      = 1'b1;
    s_valid = 1'b1;
    s_data  = A1;
    s_keep  = 8'hFF;
    s_last  = 1'b0;
    reset   = 1'b1;
    #2;
    chk("f7_rst_vb",  64'(enc_valid_bytes), 64'h0);
    chk("f7_rst_dat", enc_data, 64'h0);
    chk("f7_rst_rdy", 64'(s_ready), 64'h0);
    chk("f7_rst_cnt", 64'(frames_sent), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // After reset: full IPG then START; empty last beat ends cleanly as END0.
    idle_n("f8_ipg", IPG, 1'b1, A1);
    blk("f8_start", 1, 1, A1, 8'hFF, 0, 8'hFE, START, 0);
    blk("f8_b0",    1, 1, A1, 8'h00, 1, 8'h00, 64'h0, 1);
    chk("f8_cnt", 64'(frames_sent), 64'd1);
    chk("f8_ek",  64'(err_keep), 64'h0);
    blk("f8_ipg0",  1, 0, 64'h0, 8'h00, 0, 8'h00, 64'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
